// File: rtl/jtag_tap_ctrl_pkg.sv
// jtag_tap_ctrl_pkg
// Shared types and constants for the JTAG TAP controller.
//   tap_state_t : the 16 IEEE 1149.1 TAP controller states
//   IR_*        : instruction codes. They are held 32 bits wide so that
//                 users can cast them to any IR_WIDTH. IR_BYPASS is all
//                 ones, so it truncates to all ones at every width.
package jtag_tap_ctrl_pkg;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SH_DR,
    EX1_DR,
    PAU_DR,
    EX2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SH_IR,
    EX1_IR,
    PAU_IR,
    EX2_IR,
    UPD_IR
  } tap_state_t;

  localparam logic [31:0] IR_EXTEST = 32'h0000_0000;
  localparam logic [31:0] IR_SAMPLE = 32'h0000_0001;
  localparam logic [31:0] IR_IDCODE = 32'h0000_0002;
  localparam logic [31:0] IR_BYPASS = 32'hFFFF_FFFF;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm
// The 16-state IEEE 1149.1 TAP state machine.
// Ports:
//   tck_i   : TAP clock. State advances on posedge.
//   trst_ni : synchronous active-low reset, which forces TLR.
//   tms_i   : test mode select, which steers the state graph.
//   state_o : current TAP state.
module jtag_tap_fsm
  import jtag_tap_ctrl_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge tck_i) begin
    if (!trst_ni) state_q <= TLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms_i ? TLR    : RTI;
      RTI:     state_d = tms_i ? SEL_DR : RTI;
      SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms_i ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tms_i ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
      SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms_i ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tms_i ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl
// IEEE 1149.1 TAP controller that drives a boundary-scan register (BSR) chain.
// It contains the TAP FSM (jtag_tap_fsm), the instruction register, the
// bypass register, the optional IDCODE register and the TDO mux.
//
// Optional feature macro: JTAG_IDCODE_EN
//   defined   : a 32-bit IDCODE register exists, and IDCODE is the reset
//               instruction.
//   undefined : there is no IDCODE register, IDCODE decodes as BYPASS, and
//               BYPASS is the reset instruction.
//
// Parameters:
//   IR_WIDTH   : instruction register width (>= 2)
//   IDCODE_VAL : device ID (LSB = 1). Only used with JTAG_IDCODE_EN.
// Ports:
//   tck_i, trst_ni   : TAP clock, synchronous active-low reset
//   tms_i, tdi_i     : TAP mode select and serial data in
//   tdo_o, tdo_en_o  : serial data out, and its enable (Shift-DR/IR only)
//   bsr_ser_i/_o     : serial return from the last BSR cell / feed to the first
//   dr_shift_o       : BSR shift (1) or parallel capture (0)
//   dr_clock_o       : BSR master-FF enable
//   dr_upd_o         : BSR slave-FF enable
//   mode_o           : BSR drives the pins (EXTEST)
//   ir_o             : active instruction
//   tap_rst_o        : high in Test-Logic-Reset
module jtag_tap_ctrl
  import jtag_tap_ctrl_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                tck_i,
  input  logic                trst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_en_o,
  input  logic                bsr_ser_i,
  output logic                bsr_ser_o,
  output logic                dr_shift_o,
  output logic                dr_clock_o,
  output logic                dr_upd_o,
  output logic                mode_o,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic                tap_rst_o
);

  localparam logic [IR_WIDTH-1:0] IR_EXT_C = IR_WIDTH'(IR_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SMP_C = IR_WIDTH'(IR_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IR_CAP_C = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_ID_C  = IR_WIDTH'(IR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_RST_C = IR_ID_C;
`else
  localparam logic [IR_WIDTH-1:0] IR_RST_C = IR_WIDTH'(IR_BYPASS);
`endif

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass;
  logic                sel_bsr;
  logic                sel_id;
  logic                sel_byp;

  jtag_tap_fsm u_fsm (
    .tck_i   (tck_i),
    .trst_ni (trst_ni),
    .tms_i   (tms_i),
    .state_o (state)
  );

  // Instruction decode. Every code that is not recognised falls through to bypass.
  always_comb begin
    sel_bsr = (ir_q == IR_EXT_C) || (ir_q == IR_SMP_C);
`ifdef JTAG_IDCODE_EN
    sel_id  = (ir_q == IR_ID_C);
`else
    sel_id  = 1'b0;
`endif
    sel_byp = !sel_bsr && !sel_id;
  end

  // IR and bypass registers. ir_q changes only in TLR or UPD_IR, so the
  // instruction (and mode_o) stays stable across any DR scan.
  always_ff @(posedge tck_i) begin
    if (!trst_ni) begin
      ir_q   <= IR_RST_C;
      ir_sr  <= '0;
      bypass <= 1'b0;
    end else begin
      case (state)
        TLR:     ir_q   <= IR_RST_C;
        CAP_IR:  ir_sr  <= IR_CAP_C;
        SH_IR:   ir_sr  <= {tdi_i, ir_sr[IR_WIDTH-1:1]};
        UPD_IR:  ir_q   <= ir_sr;
        CAP_DR:  bypass <= 1'b0;
        SH_DR:   if (sel_byp) bypass <= tdi_i;
        default: ;
      endcase
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sr;

  // The IDCODE register is a data register. It is loaded on every capture,
  // so it needs no reset.
  always_ff @(posedge tck_i) begin
    if (sel_id && state == CAP_DR)     id_sr <= IDCODE_VAL;
    else if (sel_id && state == SH_DR) id_sr <= {tdi_i, id_sr[31:1]};
  end
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VAL;
`endif

  // TDO mux. The output is driven only in the two shift states.
  always_comb begin
    tdo_o    = 1'b0;
    tdo_en_o = 1'b0;
    case (state)
      SH_IR: begin
        tdo_en_o = 1'b1;
        tdo_o    = ir_sr[0];
      end
      SH_DR: begin
        tdo_en_o = 1'b1;
        if (sel_bsr)      tdo_o = bsr_ser_i;
`ifdef JTAG_IDCODE_EN
        else if (sel_id)  tdo_o = id_sr[0];
`endif
        else              tdo_o = bypass;
      end
      default: ;
    endcase
  end

  // BSR strobes are qualified by the instruction. Under BYPASS/IDCODE the
  // chain is not touched, so its update latches keep their pin values.
  assign dr_clock_o = sel_bsr && (state == CAP_DR || state == SH_DR);
  assign dr_shift_o = sel_bsr && (state == SH_DR);
  assign dr_upd_o   = sel_bsr && (state == UPD_DR);
  assign mode_o     = (ir_q == IR_EXT_C);
  assign bsr_ser_o  = tdi_i;
  assign ir_o       = ir_q;
  assign tap_rst_o  = (state == TLR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
module tb_jtag_tap_ctrl;

  logic       tck;
  logic       trst_n;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       bsr_ser_i;
  logic       bsr_ser_o;
  logic       dr_shift;
  logic       dr_clock;
  logic       dr_upd;
  logic       mode;
  logic [3:0] ir;
  logic       tap_rst;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int upd_cnt  = 0;

`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] EXP_RST_IR = 4'h2;
`else
  localparam logic [3:0] EXP_RST_IR = 4'hF;
`endif

  // 8-cell boundary chain model: master shift/capture and slave update latches
  logic [7:0] pins = 8'hA5;
  logic [7:0] chain = 8'h00;
  logic [7:0] upd_q = 8'h00;

  assign bsr_ser_i = chain[0];

  always @(posedge tck) begin
    if (dr_clock) begin
      if (dr_shift) chain <= {bsr_ser_o, chain[7:1]};
      else          chain <= pins;
    end
    if (dr_upd) begin
      upd_q   <= chain;
      upd_cnt <= upd_cnt + 1;
    end
  end

  jtag_tap_ctrl dut (
    .tck_i      (tck),
    .trst_ni    (trst_n),
    .tms_i      (tms),
    .tdi_i      (tdi),
    .tdo_o      (tdo),
    .tdo_en_o   (tdo_en),
    .bsr_ser_i  (bsr_ser_i),
    .bsr_ser_o  (bsr_ser_o),
    .dr_shift_o (dr_shift),
    .dr_clock_o (dr_clock),
    .dr_upd_o   (dr_upd),
    .mode_o     (mode),
    .ir_o       (ir),
    .tap_rst_o  (tap_rst)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic step(input logic t_tms, input logic t_tdi);
    tms = t_tms;
    tdi = t_tdi;
    @(posedge tck);
    #1;
  endtask

  // RTI -> shift v into IR -> UPD_IR -> RTI
  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    trst_n = 1'b0;
    tms    = 1'b0;
    tdi    = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    vec_cnt++;
    if (tap_rst !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reset_tlr: tap_rst=%b want 1", tap_rst);
    end
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    vec_cnt++;
    if (ir !== EXP_RST_IR) begin
      miss_cnt++;
      $display("FAIL reset_ir: ir=%h want %h", ir, EXP_RST_IR);
    end
    vec_cnt++;
    if ({tap_rst, dr_clock, dr_shift, dr_upd, mode, tdo_en, tdo} !== 7'b0) begin
      miss_cnt++;
      $display("FAIL reset_rti_outs: got %b want 0000000",
               {tap_rst, dr_clock, dr_shift, dr_upd, mode, tdo_en, tdo});
    end
  endtask

  task automatic test_tms_reset;
    int u0;
    u0 = upd_cnt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    vec_cnt++;
    if (tap_rst !== 1'b0) begin
      miss_cnt++;
      $display("FAIL tms5_early: tap_rst=%b after 4 edges want 0", tap_rst);
    end
    step(1'b1, 1'b0);
    vec_cnt++;
    if (tap_rst !== 1'b1 || ir !== EXP_RST_IR) begin
      miss_cnt++;
      $display("FAIL tms5_tlr: tap_rst=%b ir=%h want 1 %h", tap_rst, ir, EXP_RST_IR);
    end
    vec_cnt++;
    if (upd_cnt !== u0) begin
      miss_cnt++;
      $display("FAIL tms5_no_upd: upd pulses=%0d want 0", upd_cnt - u0);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_load_extest;
    logic [3:0] exp_tdo;
    exp_tdo = 4'b0001;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (tdo !== exp_tdo[i] || tdo_en !== 1'b1) begin
        miss_cnt++;
        $display("FAIL ir_shift_%0d: tdo=%b en=%b want %b 1", i, tdo, tdo_en, exp_tdo[i]);
      end
      step(i == 3, 1'b0);
    end
    step(1'b1, 1'b0);
    vec_cnt++;
    if (ir !== EXP_RST_IR || mode !== 1'b0) begin
      miss_cnt++;
      $display("FAIL ir_in_upd: ir=%h mode=%b want %h 0", ir, mode, EXP_RST_IR);
    end
    step(1'b0, 1'b0);
    vec_cnt++;
    if (ir !== 4'h0 || mode !== 1'b1) begin
      miss_cnt++;
      $display("FAIL ir_extest: ir=%h mode=%b want 0 1", ir, mode);
    end
  endtask

  task automatic test_extest_scan;
    logic [7:0] exp_tdo;
    logic [7:0] din;
    int u0;
    exp_tdo = 8'hA5;
    din     = 8'h3C;
    u0      = upd_cnt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    vec_cnt++;
    if (dr_clock !== 1'b1 || dr_shift !== 1'b0 || dr_upd !== 1'b0) begin
      miss_cnt++;
      $display("FAIL cap_dr_strobes: clk=%b sh=%b upd=%b want 1 0 0", dr_clock, dr_shift, dr_upd);
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if (dr_clock !== 1'b1 || dr_shift !== 1'b1 || tdo !== exp_tdo[i]) begin
        miss_cnt++;
        $display("FAIL sh_dr_%0d: clk=%b sh=%b tdo=%b want 1 1 %b", i, dr_clock, dr_shift, tdo, exp_tdo[i]);
      end
      if (i == 3) begin
        step(1'b1, din[i]);
        step(1'b0, 1'b0);
        vec_cnt++;
        if ({dr_clock, dr_shift, dr_upd, tdo_en, tdo} !== 5'b0) begin
          miss_cnt++;
          $display("FAIL pause_dr: got %b want 00000", {dr_clock, dr_shift, dr_upd, tdo_en, tdo});
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end else begin
        step(i == 7, din[i]);
      end
    end
    step(1'b1, 1'b0);
    vec_cnt++;
    if (dr_upd !== 1'b1 || dr_clock !== 1'b0) begin
      miss_cnt++;
      $display("FAIL upd_dr: upd=%b clk=%b want 1 0", dr_upd, dr_clock);
    end
    step(1'b0, 1'b0);
    vec_cnt++;
    if (upd_cnt - u0 !== 1 || upd_q !== 8'h3C) begin
      miss_cnt++;
      $display("FAIL extest_update: pulses=%0d upd=%h want 1 3c", upd_cnt - u0, upd_q);
    end
  endtask

  task automatic test_trst_mid_shift;
    int u0;
    u0 = upd_cnt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    trst_n = 1'b0;
    step(1'b0, 1'b0);
    vec_cnt++;
    if (tap_rst !== 1'b1 || ir !== EXP_RST_IR || mode !== 1'b0) begin
      miss_cnt++;
      $display("FAIL trst_abort: tap_rst=%b ir=%h mode=%b want 1 %h 0", tap_rst, ir, mode, EXP_RST_IR);
    end
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    vec_cnt++;
    if (upd_cnt !== u0 || upd_q !== 8'h3C) begin
      miss_cnt++;
      $display("FAIL trst_no_upd: pulses=%0d upd=%h want 0 3c", upd_cnt - u0, upd_q);
    end
  endtask

  // DR scan through a 1-bit path: shift 1,0,1,1 and expect 0,1,0,1 out
  task automatic test_bypass(input logic [3:0] instr);
    logic [3:0] pat;
    logic [3:0] exp_tdo;
    int u0;
    pat     = 4'b1101;
    exp_tdo = 4'b1010;
    load_ir(instr);
    vec_cnt++;
    if (ir !== instr || mode !== 1'b0) begin
      miss_cnt++;
      $display("FAIL byp_ir: ir=%h mode=%b want %h 0", ir, mode, instr);
    end
    u0 = upd_cnt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (tdo !== exp_tdo[i] || dr_clock !== 1'b0 || dr_shift !== 1'b0) begin
        miss_cnt++;
        $display("FAIL byp_%h_%0d: tdo=%b clk=%b sh=%b want %b 0 0", instr, i, tdo, dr_clock, dr_shift, exp_tdo[i]);
      end
      step(i == 3, pat[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    vec_cnt++;
    if (upd_cnt !== u0) begin
      miss_cnt++;
      $display("FAIL byp_no_upd: pulses=%0d want 0", upd_cnt - u0);
    end
  endtask

`ifdef JTAG_IDCODE_EN
  task automatic test_idcode;
    logic [31:0] id;
    id = 32'h1000_0001;
    trst_n = 1'b0;
    step(1'b0, 1'b0);
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      vec_cnt++;
      if (tdo !== id[i] || dr_clock !== 1'b0) begin
        miss_cnt++;
        $display("FAIL idcode_bit%0d: tdo=%b clk=%b want %b 0", i, tdo, dr_clock, id[i]);
      end
      step(i == 31, 1'b0);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask
`endif

  initial begin
    trst_n = 1'b0;
    tms    = 1'b1;
    tdi    = 1'b0;
    test_reset();
    test_tms_reset();
    test_load_extest();
    test_extest_scan();
    test_trst_mid_shift();
    step(1'b0, 1'b0);
    test_bypass(4'hF);
    test_bypass(4'h7);
`ifdef JTAG_IDCODE_EN
    test_idcode();
`else
    test_bypass(4'h2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller that drives the boundary-scan DR cell chain. It contains the 16-state TAP FSM, the instruction register, the bypass register and the TDO mux. It produces the per-cell control strobes (dr_shift, dr_clock, dr_upd, mode) consumed by every boundary cell, and receives the chain's serial output back. It sits between the chip-level JTAG pins and the boundary-scan register (BSR).

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE_VAL, 32'h1000_0001, device ID (LSB must be 1); used only with JTAG_IDCODE_EN

Ports:
tck_i  in  1  TAP clock; all state on posedge
trst_ni  in  1  synchronous active-low reset
tms_i  in  1  test mode select
tdi_i  in  1  test data in
tdo_o  out  1  test data out
tdo_en_o  out  1  high in Shift-DR/Shift-IR only
bsr_ser_i  in  1  serial output of last BSR cell
bsr_ser_o  out  1  serial input to first BSR cell (= tdi_i)
dr_shift_o  out  1  BSR: 0 = parallel capture, 1 = serial shift
dr_clock_o  out  1  BSR master-FF enable
dr_upd_o  out  1  BSR slave-FF enable
mode_o  out  1  BSR mode: 1 = register drives pins (EXTEST)
ir_o  out  IR_WIDTH  current active instruction
tap_rst_o  out  1  high while in Test-Logic-Reset

Behaviour:
- Reset is synchronous and active-low: trst_ni sampled low at posedge tck_i forces the following values:
  - state = TEST_LOGIC_RESET
  - ir_q = reset instruction
  - ir_sr = 0
  - bypass = 0
- FSM follows the standard 1149.1 graph on tms_i: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- Five consecutive tms_i=1 reach TLR from any state. In TLR, ir_q is reloaded with the reset instruction every cycle.
- Instructions (IR_WIDTH=4):
  - EXTEST = 0x0
  - SAMPLE = 0x1
  - IDCODE = 0x2
  - BYPASS = all ones
  - Any undefined code behaves as BYPASS.
- Reset instruction: IDCODE if JTAG_IDCODE_EN is defined, else BYPASS.
- IR path:
  - CAP_IR: ir_sr <= {0..., 2'b01}.
  - SH_IR: ir_sr <= {tdi_i, ir_sr[IR_WIDTH-1:1]}; tdo_o = ir_sr[0].
  - UPD_IR: ir_q <= ir_sr. New instruction is active from the cycle after UPD_IR.
- BSR strobes are combinational decodes of the current state, and are asserted only when ir_q is EXTEST or SAMPLE:
  - CAP_DR: dr_clock_o=1, dr_shift_o=0
  - SH_DR: dr_clock_o=1, dr_shift_o=1
  - UPD_DR: dr_upd_o=1
  - all others: all three 0
- Each cell therefore captures at the posedge ending CAP_DR and shifts at every posedge ending SH_DR.
- mode_o = 1 iff ir_q == EXTEST. It changes only via UPD_IR or TLR.
- Bypass register:
  - CAP_DR: bypass <= 0.
  - SH_DR with BYPASS selected: bypass <= tdi_i.
- tdo_o in SH_DR by instruction:
  - EXTEST/SAMPLE: bsr_ser_i
  - IDCODE: id_sr[0]
  - BYPASS: bypass
- tdo_o is 0 outside SH_DR/SH_IR. tdo_en_o is asserted in exactly those two states.
- Pause states hold all shift registers unchanged; all strobes are 0 in pause.
- Reset mid-shift: the shift is aborted, no update occurs and BSR outputs are unaffected.

Optional Feature:
JTAG_IDCODE_EN
- Defined:
  - 32-bit id_sr loads IDCODE_VAL in CAP_DR when ir_q==IDCODE, and shifts right in SH_DR with tdi_i into bit 31.
  - Reset instruction is IDCODE.
- Undefined:
  - No id_sr exists; IDCODE decodes as BYPASS.
  - Reset instruction is BYPASS.

Decomposition:
- as_pack gains:
  - tap_state_t enum (16 states)
  - IR_EXTEST, IR_SAMPLE, IR_IDCODE, IR_BYPASS constants
- Sub-module jtag_tap_fsm holds the state register and next-state logic, and outputs the state.
- Instruction decode, the registers and the TDO mux remain in jtag_tap_ctrl.

Test Plan:
- Reset: trst_ni=0 for 2 cycles, then TMS=0 -> state RTI; ir_o=0x2 (feature on) or 0xF (off); all strobes 0; mode_o=0.
- TMS 1,1,1,1,1 from SH_DR mid-shift -> TLR after 5th edge; ir_o = reset value; no dr_upd_o pulse.
- Load EXTEST: from RTI, TMS 1,1,0,0 then shift TDI 0,0,0,0 with TMS=0,0,0,1, then TMS 1,0 -> tdo_o shows 1,0,0,0 (captured 01); ir_o=0x0 and mode_o=1 the cycle after UPD_IR.
- EXTEST DR scan, 8-cell chain model: CAP_DR one cycle with dr_clock_o=1 and dr_shift_o=0; 8 SH_DR cycles with dr_shift_o=1 and tdo_o=bsr_ser_i; single dr_upd_o pulse in UPD_DR.
- BYPASS: shift pattern 1,0,1,1 through DR -> tdo_o = 0,1,0,1 (one-cycle delay, first bit 0); BSR strobes stay 0.
- IDCODE (feature on): after reset, 32 SH_DR cycles -> tdo_o serialises 0x1000_0001 LSB first.
